// File: rtl/except_ctrl_pkg.sv
// Shared exception-control definitions: exception codes, raw flag bit positions,
// vector constants and controller state encoding. The CP0 block reuses this package.
package except_ctrl_pkg;

    typedef enum logic [3:0] {
        EXC_NONE = 4'd0,
        EXC_INT  = 4'd1,
        EXC_IF   = 4'd2,
        EXC_RI   = 4'd3,
        EXC_OV   = 4'd4,
        EXC_BP   = 4'd5,
        EXC_SYS  = 4'd6,
        EXC_ADEL = 4'd7,
        EXC_ADES = 4'd8,
        EXC_ERET = 4'd9
    } exc_type_e;

    localparam int FLAG_FETCH_ADEL = 0;
    localparam int FLAG_RI         = 1;
    localparam int FLAG_OV         = 2;
    localparam int FLAG_BP         = 3;
    localparam int FLAG_SYS        = 4;
    localparam int FLAG_DATA_ADEL  = 5;
    localparam int FLAG_ADES       = 6;
    localparam int FLAG_ERET       = 7;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;

    localparam logic [31:0] BEV_VECTOR     = 32'hBFC0_0380;
    localparam logic [11:0] EXC_VEC_OFFSET = 12'h180;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        BVA_NONE = 2'd0,
        BVA_PC   = 2'd1,
        BVA_ADDR = 2'd2
    } bva_sel_e;

    function automatic logic int_pending(input logic       ie,
                                         input logic       exl,
                                         input logic [7:0] im,
                                         input logic [7:0] ip);
        return ie & ~exl & (|(im & ip));
    endfunction

    // Offset is concatenated rather than added, so the low ebase bits never carry.
    function automatic logic [31:0] ebase_vector(input logic [19:0] ebase_hi);
        return {ebase_hi, EXC_VEC_OFFSET};
    endfunction

endpackage

// File: rtl/except_ctrl_exc_prio_enc.sv
// Pure priority encoder: picks the single highest-priority exception from the
// pending interrupt and raw MEM-stage flags, plus which value feeds badvaddr.
module exc_prio_enc
    import except_ctrl_pkg::*;
(
    input  logic [7:0] exc_flags,
    input  logic       int_pend,
    output exc_type_e  exc_type,
    output bva_sel_e   bva_sel
);

    always_comb begin
        exc_type = EXC_NONE;
        bva_sel  = BVA_NONE;
        if (int_pend) begin
            exc_type = EXC_INT;
        end else if (exc_flags[FLAG_FETCH_ADEL]) begin
            exc_type = EXC_IF;
            bva_sel  = BVA_PC;
        end else if (exc_flags[FLAG_RI]) begin
            exc_type = EXC_RI;
        end else if (exc_flags[FLAG_OV]) begin
            exc_type = EXC_OV;
        end else if (exc_flags[FLAG_BP]) begin
            exc_type = EXC_BP;
        end else if (exc_flags[FLAG_SYS]) begin
            exc_type = EXC_SYS;
        end else if (exc_flags[FLAG_DATA_ADEL]) begin
            exc_type = EXC_ADEL;
            bva_sel  = BVA_ADDR;
        end else if (exc_flags[FLAG_ADES]) begin
            exc_type = EXC_ADES;
            bva_sel  = BVA_ADDR;
        end else if (exc_flags[FLAG_ERET]) begin
            exc_type = EXC_ERET;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: reports the committing exception to CP0, flushes
// the pipeline and holds a PC redirect until fetch accepts it. Optional BEV vector
// selection is enabled by defining EXCEPT_CTRL_BEV_EN.
module except_ctrl
    import except_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_delayslot,
    input  logic [7:0]  mem_exc_flags,
    input  logic [31:0] mem_addr,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_ebase,
    input  logic        redirect_ready,
    output logic        mem_ready,
    output logic [3:0]  exc_type,
    output logic        exc_delayslot,
    output logic [31:0] exc_pc,
    output logic [31:0] exc_badvaddr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    ctrl_state_e state_q, state_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        int_pend;
    exc_type_e   enc_type;
    bva_sel_e    enc_bva_sel;
    logic        take;
    exc_type_e   exc_type_sel;
    logic [31:0] vector_pc;
    logic [31:0] target_pc;
    logic        unused_cp0;

    assign int_pend = int_pending(cp0_status[STATUS_IE], cp0_status[STATUS_EXL],
                                  cp0_status[15:8], cp0_cause[15:8]);

    exc_prio_enc u_prio_enc (
        .exc_flags (mem_exc_flags),
        .int_pend  (int_pend),
        .exc_type  (enc_type),
        .bva_sel   (enc_bva_sel)
    );

    // Exceptions are only reported while idle, out of reset, with a real instruction.
    assign take         = rst & (state_q == ST_IDLE) & mem_valid;
    assign exc_type_sel = take ? enc_type : EXC_NONE;

    assign exc_type      = exc_type_sel;
    assign exc_pc        = take ? mem_pc : 32'h0;
    assign exc_delayslot = take & mem_delayslot;
    assign mem_ready     = rst & (state_q == ST_IDLE);

    always_comb begin
        exc_badvaddr = 32'h0;
        if (take) begin
            case (enc_bva_sel)
                BVA_PC:   exc_badvaddr = mem_pc;
                BVA_ADDR: exc_badvaddr = mem_addr;
                default:  exc_badvaddr = 32'h0;
            endcase
        end
    end

`ifdef EXCEPT_CTRL_BEV_EN
    assign vector_pc = cp0_status[STATUS_BEV] ? BEV_VECTOR : ebase_vector(cp0_ebase[31:12]);
`else
    assign vector_pc = ebase_vector(cp0_ebase[31:12]);
`endif

    assign target_pc  = (exc_type_sel == EXC_ERET) ? cp0_epc : vector_pc;
    assign unused_cp0 = ^{cp0_status, cp0_cause, cp0_ebase[11:0]};

    always_comb begin
        state_d          = state_q;
        flush_d          = 1'b0;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        if (!rst) begin
            state_d          = ST_IDLE;
            redirect_valid_d = 1'b0;
            redirect_pc_d    = 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (exc_type_sel != EXC_NONE) begin
                        state_d          = ST_HOLD;
                        flush_d          = 1'b1;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = target_pc;
                    end
                end
                ST_HOLD: begin
                    if (redirect_ready) begin
                        state_d          = ST_DRAIN;
                        redirect_valid_d = 1'b0;
                    end
                end
                // One quiet cycle so the CP0 EXL update is visible before new commits.
                ST_DRAIN: state_d = ST_IDLE;
                default: begin
                    state_d          = ST_IDLE;
                    redirect_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q          <= state_d;
        flush_q          <= flush_d;
        redirect_valid_q <= redirect_valid_d;
        redirect_pc_q    <= redirect_pc_d;
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 clk  in  1  core clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-low.
REQ-003 mem_valid  in  1  a committing instruction is present in MEM this cycle.
REQ-004 mem_pc  in  32  PC of that instruction.
REQ-005 mem_delayslot  in  1  instruction sits in a branch delay slot.
REQ-006 mem_exc_flags  in  8  one-hot-or-more raw flags, bit0..7: fetch_adel, ri, ov, bp, sys, data_adel, ades, eret.
REQ-007 mem_addr  in  32  data address of the load/store.
REQ-008 cp0_status, cp0_cause, cp0_epc, cp0_ebase  in  32 each  current CP0 register values.
REQ-009 redirect_ready  in  1  fetch stage accepts redirect this cycle.
REQ-010 mem_ready  out  1  MEM may retire; low while a redirect is outstanding.
REQ-011 exc_type  out  4  encoded exception sent to CP0: 0 none, 1 INT, 2 IF, 3 RI, 4 OV, 5 BP, 6 SYS, 7 ADEL, 8 ADES, 9 ERET.
REQ-012 exc_delayslot  out  1 / exc_pc  out  32 / exc_badvaddr  out  32  exception context to CP0.
REQ-013 flush  out  1  registered one-cycle pipeline flush pulse.
REQ-014 redirect_valid  out  1 / redirect_pc  out  32  registered PC redirect to fetch.

Function
REQ-015 Interrupt pending = status[0] & ~status[1] & |(cause[15:8] & status[15:8]); taken only with mem_valid high in IDLE.
REQ-016 Priority, highest first: INT, IF, RI, OV, BP, SYS, ADEL, ADES, ERET; only the highest is encoded.
REQ-017 exc_type/exc_pc/exc_delayslot combinational, nonzero only in IDLE with mem_valid; zero otherwise.
REQ-018 exc_badvaddr = mem_pc for IF, mem_addr for ADEL/ADES, 0 otherwise.
REQ-019 States: IDLE, HOLD, DRAIN. IDLE & exc_type!=0 -> HOLD next cycle, flush=1 for exactly that cycle, redirect_valid=1, redirect_pc latched.
REQ-020 HOLD: redirect_valid held, redirect_pc stable, mem_ready=0; redirect_ready=1 -> DRAIN.
REQ-021 DRAIN: one cycle, mem_ready=0, exc_type=0 (lets CP0 EXL update settle); -> IDLE.
REQ-022 redirect_ready already high on the HOLD entry cycle: HOLD lasts one cycle.
REQ-023 redirect_pc = cp0_epc for ERET; else exception vector (see Configuration).
REQ-024 Interrupt arriving in HOLD/DRAIN is not lost: re-evaluated in IDLE from live CP0 state.
REQ-025 Vector arithmetic: 32-bit, ebase[31:12] concatenated with 12'h180; no carry.
REQ-026 mem_ready=1 in IDLE.

Reset
REQ-027 rst low at clock edge: state=IDLE, flush=0, redirect_valid=0, redirect_pc=0; applies mid-HOLD, discarding the redirect.
REQ-028 During reset exc_type=0, exc_badvaddr=0, mem_ready=0.

Configuration
REQ-029 EXCEPT_CTRL_BEV_EN defined: status[22]=1 selects vector 32'hBFC0_0380, status[22]=0 selects ebase-based vector.
REQ-030 EXCEPT_CTRL_BEV_EN undefined: always ebase-based vector; status[22] ignored.

Structure
REQ-031 exc_type encodings, flag bit positions, vector constants, state encodings in shared package/defines header reused by CP0.
REQ-032 One sub-module exc_prio_enc: pure priority encoder from flags+int_pending to exc_type/badvaddr select.

Verification
REQ-033 IDLE, mem_valid, flags=8'h04 (ov), pc=32'h8000_1000, ebase=32'h8000_0000 -> exc_type=4, flush pulse next cycle, redirect_pc=32'h8000_0180.
REQ-034 Flags=8'h42 (ri+ades), mem_addr=32'h0000_0003 -> exc_type=3, exc_badvaddr=0.
REQ-035 status=32'h0000_0401, cause=32'h0000_0400, flags=8'h10 (sys) -> exc_type=1 (INT wins).
REQ-036 Flags=8'h80, epc=32'h8000_2004, redirect_ready low 3 cycles -> redirect_valid held 4 cycles, mem_ready=0 through DRAIN, redirect_pc=32'h8000_2004.
REQ-037 BEV_EN defined, status[22]=1, flags=8'h01, pc=32'h8000_0001 -> exc_type=2, badvaddr=32'h8000_0001, redirect_pc=32'hBFC0_0380.
REQ-038 rst low during HOLD -> next cycle redirect_valid=0, state IDLE, no flush.
